cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, all state on rising edge; rst_n  in  1  async active-low reset.
REQ-002 SHALL have ports:
- req_valid  in  1  access request, held by requester while stall=1
- req_addr  in  16  byte address: tag=[15:10], set=[9:4], offset=[3:0]
- meta_out0  in  8  way-0 metadata byte of the enabled set
- meta_out1  in  8  way-1 metadata byte of the enabled set
- set_enable  out  64  one-hot set select to the metadata and data arrays
- meta_wr0  out  1  way-0 metadata write
- meta_wr1  out  1  way-1 metadata write
- meta_din  out  8  metadata write data
- data_wr0  out  1  way-0 data write
- data_wr1  out  1  way-1 data write
- data_word_en  out  8  one-hot word select within the 16-byte block
- data_din  out  16  fill word, equals mem_data
- mem_rd_en  out  1  memory read issue
- mem_addr  out  16  memory word address
- mem_valid  in  1  memory read data valid, 4 cycles after issue
- mem_data  in  16  memory read data
- hit  out  1  request hit this cycle
- stall  out  1  requester must hold
- fill_done  out  1  one-cycle pulse when a fill completes

Function
REQ-003 Metadata byte SHALL be bit7=valid, bit6=LRU, bits5:0=tag; LRU SHALL be meaningful in way 0 only (0: way 0 is victim, 1: way 1 is victim); way-1 bit6 SHALL always be written 0.
REQ-004 SHALL use states IDLE, LRU_UPD, FILL, META_WR, LRU_WR.
REQ-005 In IDLE, set_enable SHALL be the one-hot of req_addr[9:4], and metadata reads SHALL be combinational from meta_out0/1.
REQ-006 In IDLE with req_valid, hitN SHALL be meta_outN[7] & (meta_outN[5:0]==req_addr[15:10]); hit=hit0|hit1 in the same cycle, with stall=0.
REQ-007 On a hit whose way-0 LRU bit is wrong (a way-0 hit with bit6=0, or a way-1 hit with bit6=1), SHALL latch meta_out0 and move to LRU_UPD.
REQ-008 In LRU_UPD, SHALL for one cycle assert meta_wr0 with meta_din = {latched bit7, hit0?1:0, latched tag}, stall=1, and return to IDLE.
REQ-009 On a miss, SHALL latch tag, set and victim and enter FILL with stall=1.
- Victim: way 0 if way 0 is invalid; else way 1 if way 1 is invalid; else way-0 bit6.
REQ-010 In FILL, SHALL issue 8 reads on consecutive cycles.
- mem_rd_en=1 and mem_addr={tag,set,issue_cnt[2:0],1'b0}.
- issue_cnt SHALL count 0..8 and saturate at 8.
REQ-011 Each mem_valid in FILL SHALL assert data_wrV for the victim way, data_word_en=one-hot(ret_cnt), data_din=mem_data, and increment ret_cnt.
REQ-012 The 8th return SHALL move FILL to META_WR; nominal fill SHALL be 12 cycles (issue cycles 1-8, returns cycles 5-12).
REQ-013 In META_WR for victim 0, SHALL assert meta_wr0 with meta_din={1,1,tag} and fill_done, then go to IDLE.
REQ-014 In META_WR for victim 1, SHALL assert meta_wr1 with meta_din={1,0,tag}, then go to LRU_WR.
REQ-015 In LRU_WR, SHALL assert meta_wr0 with meta_din={latched meta_out0[7],0,latched meta_out0[5:0]} and fill_done, then go to IDLE.
REQ-016 Outside IDLE, set_enable SHALL be the one-hot of the latched set.
REQ-017 SHALL never assert meta_wr0 and meta_wr1 in the same cycle; SHALL never depend on meta_out while any meta_wr is high, because array outputs are high-Z during writes.
REQ-018 The requester re-presents the same address after fill_done; that access SHALL hit.
REQ-019 mem_valid in IDLE or LRU_UPD SHALL be ignored; req_valid SHALL be ignored in all states but IDLE.
REQ-020 In IDLE with req_valid=0, hit=0 and stall=0.

Reset
REQ-021 rst_n low SHALL, asynchronously, force IDLE and clear both counters and all latched registers.
REQ-022 During reset, all outputs SHALL be 0, including set_enable, hit, stall and fill_done.
REQ-023 Reset mid-FILL SHALL abandon the fill with no metadata write; memory returns after release SHALL be ignored.

Verification
REQ-024 Cold miss: after reset, req addr 0x1234 (tag 0x04, set 0x23), memory returns 0xA000+i -> 8 data writes to way 0 word i, meta_wr0 with din 0xC4, fill_done in cycle 13; re-presented request gives hit=1, stall=0.
REQ-025 Second tag, same set: 0x5234 after the REQ-024 fill -> victim way 1; meta_wr1 with din 0x94, then meta_wr0 with din 0x84 in the next cycle.
REQ-026 LRU hit update: after REQ-025, hit on 0x1234 -> hit=1, one LRU_UPD cycle, meta_wr0 with din 0xC4; an immediate repeat of 0x1234 -> hit with no write.
REQ-027 Eviction: after REQ-026, miss on 0x9234 -> victim way 1, mem_addr sequence 0x9230, 0x9232 ... 0x923E.
REQ-028 Reset at fill cycle 6 -> all outputs 0 immediately; after release, request 0x1234 misses again.

Source files
------------

// File: rtl/cache_ctrl.sv
`timescale 1ns/1ps
// Two-way set-associative cache controller: hit detection, LRU maintenance and
// 8-beat block fill from a 4-cycle-latency memory with metadata write-back.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  meta_out0_i,
  input  logic [7:0]  meta_out1_i,
  output logic [63:0] set_enable_o,
  output logic        meta_wr0_o,
  output logic        meta_wr1_o,
  output logic [7:0]  meta_din_o,
  output logic        data_wr0_o,
  output logic        data_wr1_o,
  output logic [7:0]  data_word_en_o,
  output logic [15:0] data_din_o,
  output logic        mem_rd_en_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [15:0] mem_data_i,
  output logic        hit_o,
  output logic        stall_o,
  output logic        fill_done_o
);

  typedef enum logic [2:0] {StIdle, StLruUpd, StFill, StMetaWr, StLruWr} state_e;

  state_e      state_q, state_d;
  logic [5:0]  tag_q, tag_d;
  logic [5:0]  set_q, set_d;
  logic        victim_q, victim_d;
  logic [7:0]  meta0_q, meta0_d;
  logic        hit0_q, hit0_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  ret_cnt_q, ret_cnt_d;

  logic [5:0]  req_tag;
  logic [5:0]  req_set;
  logic        hit0;
  logic        hit1;
  logic        unused_bits;

  assign req_tag     = req_addr_i[15:10];
  assign req_set     = req_addr_i[9:4];
  assign hit0        = meta_out0_i[7] & (meta_out0_i[5:0] == req_tag);
  assign hit1        = meta_out1_i[7] & (meta_out1_i[5:0] == req_tag);
  assign unused_bits = ^{meta_out1_i[6], req_addr_i[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      set_q       <= '0;
      victim_q    <= 1'b0;
      meta0_q     <= '0;
      hit0_q      <= 1'b0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      victim_q    <= victim_d;
      meta0_q     <= meta0_d;
      hit0_q      <= hit0_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    set_d          = set_q;
    victim_d       = victim_q;
    meta0_d        = meta0_q;
    hit0_d         = hit0_q;
    issue_cnt_d    = issue_cnt_q;
    ret_cnt_d      = ret_cnt_q;
    set_enable_o   = 64'd1 << set_q;
    meta_wr0_o     = 1'b0;
    meta_wr1_o     = 1'b0;
    meta_din_o     = '0;
    data_wr0_o     = 1'b0;
    data_wr1_o     = 1'b0;
    data_word_en_o = '0;
    data_din_o     = '0;
    mem_rd_en_o    = 1'b0;
    mem_addr_o     = '0;
    hit_o          = 1'b0;
    stall_o        = 1'b1;
    fill_done_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        set_enable_o = 64'd1 << req_set;
        stall_o      = 1'b0;
        if (req_valid_i) begin
          if (hit0 || hit1) begin
            hit_o = 1'b1;
            // Way 0 always wins if both ways somehow match.
            if ((hit0 && !meta_out0_i[6]) || (!hit0 && meta_out0_i[6])) begin
              meta0_d = meta_out0_i;
              hit0_d  = hit0;
              state_d = StLruUpd;
            end
          end else begin
            stall_o     = 1'b1;
            tag_d       = req_tag;
            set_d       = req_set;
            meta0_d     = meta_out0_i;
            victim_d    = !meta_out0_i[7] ? 1'b0 :
                          !meta_out1_i[7] ? 1'b1 : meta_out0_i[6];
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            state_d     = StFill;
          end
        end
      end
      StLruUpd: begin
        meta_wr0_o = 1'b1;
        meta_din_o = {meta0_q[7], hit0_q, meta0_q[5:0]};
        state_d    = StIdle;
      end
      StFill: begin
        if (issue_cnt_q < 4'd8) begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = {tag_q, set_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (mem_valid_i) begin
          data_wr0_o     = !victim_q;
          data_wr1_o     = victim_q;
          data_word_en_o = 8'd1 << ret_cnt_q[2:0];
          data_din_o     = mem_data_i;
          ret_cnt_d      = ret_cnt_q + 4'd1;
          if (ret_cnt_q == 4'd7) begin
            state_d = StMetaWr;
          end
        end
      end
      StMetaWr: begin
        if (!victim_q) begin
          meta_wr0_o  = 1'b1;
          meta_din_o  = {2'b11, tag_q};
          fill_done_o = 1'b1;
          state_d     = StIdle;
        end else begin
          meta_wr1_o = 1'b1;
          meta_din_o = {2'b10, tag_q};
          state_d    = StLruWr;
        end
      end
      StLruWr: begin
        // Way 1 was just filled, so way 0 becomes the next victim.
        meta_wr0_o  = 1'b1;
        meta_din_o  = {meta0_q[7], 1'b0, meta0_q[5:0]};
        fill_done_o = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Every output is held low while reset is asserted, including the
    // combinational set decode in idle.
    if (!rst_n) begin
      set_enable_o   = '0;
      meta_wr0_o     = 1'b0;
      meta_wr1_o     = 1'b0;
      meta_din_o     = '0;
      data_wr0_o     = 1'b0;
      data_wr1_o     = 1'b0;
      data_word_en_o = '0;
      data_din_o     = '0;
      mem_rd_en_o    = 1'b0;
      mem_addr_o     = '0;
      hit_o          = 1'b0;
      stall_o        = 1'b0;
      fill_done_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for cache_ctrl: memory and metadata array models, directed
// accesses with expected array/memory traffic queued ahead of the DUT.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [7:0]  meta_out0;
  logic [7:0]  meta_out1;
  logic [63:0] set_enable;
  logic        meta_wr0;
  logic        meta_wr1;
  logic [7:0]  meta_din;
  logic        data_wr0;
  logic        data_wr1;
  logic [7:0]  data_word_en;
  logic [15:0] data_din;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        hit;
  logic        stall;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .meta_out0_i    (meta_out0),
    .meta_out1_i    (meta_out1),
    .set_enable_o   (set_enable),
    .meta_wr0_o     (meta_wr0),
    .meta_wr1_o     (meta_wr1),
    .meta_din_o     (meta_din),
    .data_wr0_o     (data_wr0),
    .data_wr1_o     (data_wr1),
    .data_word_en_o (data_word_en),
    .data_din_o     (data_din),
    .mem_rd_en_o    (mem_rd_en),
    .mem_addr_o     (mem_addr),
    .mem_valid_i    (mem_valid),
    .mem_data_i     (mem_data),
    .hit_o          (hit),
    .stall_o        (stall),
    .fill_done_o    (fill_done)
  );

  // Metadata array model, addressed by the one-hot set enable.
  logic       clear_meta = 1'b0;
  logic [7:0] meta0_arr [64];
  logic [7:0] meta1_arr [64];
  int         set_idx;

  always_comb begin
    set_idx = 0;
    for (int i = 0; i < 64; i++) if (set_enable[i]) set_idx = i;
  end
  assign meta_out0 = meta0_arr[set_idx[5:0]];
  assign meta_out1 = meta1_arr[set_idx[5:0]];

  always @(posedge clk) begin
    if (clear_meta) begin
      for (int i = 0; i < 64; i++) begin
        meta0_arr[i] <= 8'h00;
        meta1_arr[i] <= 8'h00;
      end
    end else begin
      if (meta_wr0) meta0_arr[set_idx[5:0]] <= meta_din;
      if (meta_wr1) meta1_arr[set_idx[5:0]] <= meta_din;
    end
  end

  // Memory model: data 0xA000+word arrives 4 cycles after issue.
  logic [3:0] mem_pipe_v = 4'd0;
  logic [2:0] mem_pipe_w [4];

  always @(posedge clk) begin
    mem_pipe_v    <= {mem_pipe_v[2:0], mem_rd_en};
    mem_pipe_w[0] <= mem_addr[3:1];
    for (int i = 1; i < 4; i++) mem_pipe_w[i] <= mem_pipe_w[i-1];
  end
  assign mem_valid = mem_pipe_v[3];
  assign mem_data  = 16'hA000 + {13'd0, mem_pipe_w[3]};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event kinds: 0 memory read, 1 data write, 2 metadata write.
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;
  ev_t exp_q[$];

  task automatic check_ev(input logic [33:0] act, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s unexpected: got %0h expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_en) check_ev({2'd0, 16'd0, mem_addr}, "mem_rd");
    if (data_wr0 || data_wr1) begin
      chk("data_wr_excl", 64'(data_wr0 & data_wr1), 64'd0);
      check_ev({2'd1, 7'd0, data_wr1, data_word_en, data_din}, "data_wr");
    end
    if (meta_wr0 || meta_wr1) begin
      chk("meta_wr_excl", 64'(meta_wr0 & meta_wr1), 64'd0);
      check_ev({2'd2, 16'd0, set_idx[5:0], fill_done, meta_wr1, meta_din}, "meta_wr");
    end else if (fill_done) begin
      chk("fill_done_without_meta_wr", 64'(fill_done), 64'd0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_set_enable"}, set_enable, 64'd0);
    chk({tag, "_hit"}, 64'(hit), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_fill_done"}, 64'(fill_done), 64'd0);
    chk({tag, "_others"},
        64'({meta_wr0, meta_wr1, meta_din, data_wr0, data_wr1, data_word_en, data_din,
             mem_rd_en, mem_addr}), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the re-presented hit.
  task automatic do_miss(input logic [15:0] addr, input logic victim,
                         input logic [7:0] lru_din, input int exp_cyc);
    logic [5:0] tg;
    logic [5:0] st;
    int         cyc;
    bit         done;
    tg = addr[15:10];
    st = addr[9:4];
    for (int c = 1; c <= 12; c++) begin
      if (c <= 8) exp_q.push_back({2'd0, 16'd0, tg, st, 3'(c - 1), 1'b0});
      if (c >= 5) exp_q.push_back({2'd1, 7'd0, victim, 8'(1 << (c - 5)), 16'hA000 + 16'(c - 5)});
    end
    if (!victim) begin
      exp_q.push_back({2'd2, 16'd0, st, 1'b1, 1'b0, 2'b11, tg});
    end else begin
      exp_q.push_back({2'd2, 16'd0, st, 1'b0, 1'b1, 2'b10, tg});
      exp_q.push_back({2'd2, 16'd0, st, 1'b1, 1'b0, lru_din});
    end
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    chk("miss_hit", 64'(hit), 64'd0);
    chk("miss_stall", 64'(stall), 64'd1);
    cyc  = 0;
    done = 1'b0;
    while (cyc < 40 && !done) begin
      @(negedge clk);
      cyc++;
      if (fill_done) done = 1'b1;
    end
    chk("fill_done_seen", 64'(done), 64'd1);
    chk("fill_done_cycle", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    chk("refill_hit", 64'(hit), 64'd1);
    chk("refill_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 16'h1234;
    clear_meta = 1'b1;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_meta = 1'b0;
    req_valid  = 1'b0;
    rst_n      = 1'b1;

    @(negedge clk);
    chk("idle_hit", 64'(hit), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_set_enable", set_enable, 64'h0000_0008_0000_0000);
    @(posedge clk);
    #1;

    // Cold miss, second tag to way 1, then LRU-correcting hit.
    do_miss(16'h1234, 1'b0, 8'h00, 13);
    do_miss(16'h5234, 1'b1, 8'h84, 14);

    exp_q.push_back({2'd2, 16'd0, 6'h23, 1'b0, 1'b0, 8'hC4});
    req_valid = 1'b1;
    req_addr  = 16'h1234;
    @(negedge clk);
    chk("lru_hit", 64'(hit), 64'd1);
    chk("lru_hit_stall", 64'(stall), 64'd0);
    @(negedge clk);
    chk("lru_upd_stall", 64'(stall), 64'd1);
    chk("lru_upd_hit", 64'(hit), 64'd0);
    @(negedge clk);
    chk("repeat_hit", 64'(hit), 64'd1);
    chk("repeat_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;

    // Eviction of way 1 (LRU points at way 1).
    do_miss(16'h9234, 1'b1, 8'h84, 14);

    // Reset in fill cycle 6 from an empty cache.
    clear_meta = 1'b1;
    @(posedge clk);
    #1 clear_meta = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_q.push_back({2'd0, 16'd0, 6'h04, 6'h23, 3'(c - 1), 1'b0});
      if (c == 5) exp_q.push_back({2'd1, 7'd0, 1'b0, 8'h01, 16'hA000});
    end
    req_valid = 1'b1;
    req_addr  = 16'h1234;
    @(negedge clk);
    chk("rst_fill_miss_stall", 64'(stall), 64'd1);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midfill_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b1;
    for (int c = 0; c < 6; c++) @(posedge clk);
    #1;
    do_miss(16'h1234, 1'b0, 8'h00, 13);

    for (int c = 0; c < 4; c++) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
